// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-sequencing controller for the 5-stage pipeline.
// Arbitrates same-cycle exception, redirect, IRQ and load-use requests.
// It drives the IF stage's PC select, flush, pause and trap-vector controls, and ID_Flush.
// Redirect and stall controls are combinational (zero latency).
// Trap vector strobes (intruption/exception/irq_ack) are registered and
// appear in the single TRAP cycle that follows acceptance.
// Optional build macro FETCH_CTRL_IRQ_MASK_EN adds an eret input and an
// internal IRQ enable that is cleared on every trap entry.
module fetch_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int IRQ_SYNC     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       branch_taken,
  input  logic       jump,
  input  logic       jr,
  input  logic       load_use,
  input  logic       exc_req,
  input  logic       irq_req,
  input  logic       kernel_mode,
`ifdef FETCH_CTRL_IRQ_MASK_EN
  input  logic       eret,
`endif
  output logic [2:0] PCSrc,
  output logic       IF_Flush,
  output logic       IF_Pause,
  output logic       ID_Flush,
  output logic       intruption,
  output logic       exception,
  output logic       irq_ack
);

  typedef enum logic [1:0] {RUN, STALL, TRAP} state_t;

  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

  localparam logic [2:0] SEL_PC4 = 3'b000;
  localparam logic [2:0] SEL_B   = 3'b001;
  localparam logic [2:0] SEL_J   = 3'b010;
  localparam logic [2:0] SEL_JR  = 3'b100;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          stall_cnt;
  logic [2:0]          stall_cnt_nxt;
  logic                exc_pend;
  logic                exc_pend_nxt;
  logic [IRQ_SYNC-1:0] irq_sync;
  logic                irq_s;
  logic                irq_ok;
  logic                trap_irq;
  logic                trap_exc;
  logic [2:0]          pcsrc_c;
  logic                if_flush_c;
  logic                if_pause_c;
  logic                id_flush_c;

  assign irq_s = irq_sync[IRQ_SYNC-1];

`ifdef FETCH_CTRL_IRQ_MASK_EN
  logic irq_en;

  // IRQ enable: dropped on every trap entry, re-armed by an eret pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b1;
    end else if (trap_irq || trap_exc) begin
      irq_en <= 1'b0;
    end else if (eret) begin
      irq_en <= 1'b1;
    end
  end

  assign irq_ok = irq_s & irq_en;
`else
  assign irq_ok = irq_s;
`endif

  // Synchronizer chain for the asynchronous interrupt level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync <= '0;
    end else begin
      irq_sync <= {irq_sync[IRQ_SYNC-2:0], irq_req};
    end
  end

  // Request arbitration: next state, stall/pending bookkeeping and fetch controls
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    exc_pend_nxt  = exc_pend;
    trap_irq      = 1'b0;
    trap_exc      = 1'b0;
    pcsrc_c       = SEL_PC4;
    if_flush_c    = 1'b0;
    if_pause_c    = 1'b0;
    id_flush_c    = 1'b0;
    unique case (state)
      RUN: begin
        if ((exc_pend || exc_req) && !kernel_mode) begin
          // Exceptions outrank everything; pending one is consumed here
          trap_exc     = 1'b1;
          exc_pend_nxt = 1'b0;
          if_flush_c   = 1'b1;
          id_flush_c   = 1'b1;
        end else begin
          // An exception raised in kernel mode waits for user mode
          if (exc_req) begin
            exc_pend_nxt = 1'b1;
          end
          if (branch_taken) begin
            // Younger jump/jr/load-use are on the wrong path and dropped
            pcsrc_c    = SEL_B;
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
          end else if (jr) begin
            pcsrc_c    = SEL_JR;
            if_flush_c = 1'b1;
          end else if (jump) begin
            pcsrc_c    = SEL_J;
            if_flush_c = 1'b1;
          end else if (irq_ok && !kernel_mode) begin
            trap_irq   = 1'b1;
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
          end else if (load_use) begin
            // This cycle is the first bubble; STALL covers the remainder
            if_pause_c    = 1'b1;
            id_flush_c    = 1'b1;
            stall_cnt_nxt = STALL_INIT;
            if (STALL_CYCLES > 1) begin
              state_nxt = STALL;
            end
          end
        end
      end
      STALL: begin
        if (exc_req && !kernel_mode) begin
          trap_exc      = 1'b1;
          exc_pend_nxt  = 1'b0;
          stall_cnt_nxt = 3'd0;
          if_flush_c    = 1'b1;
          id_flush_c    = 1'b1;
        end else begin
          if (exc_req) begin
            exc_pend_nxt = 1'b1;
          end
          if (branch_taken) begin
            // Redirect makes the stalled instruction irrelevant
            pcsrc_c       = SEL_B;
            if_flush_c    = 1'b1;
            id_flush_c    = 1'b1;
            stall_cnt_nxt = 3'd0;
            state_nxt     = RUN;
          end else begin
            if_pause_c    = 1'b1;
            id_flush_c    = 1'b1;
            stall_cnt_nxt = (stall_cnt != 3'd0) ? stall_cnt - 3'd1 : 3'd0;
            if (stall_cnt <= 3'd1) begin
              state_nxt = RUN;
            end
          end
        end
      end
      TRAP: begin
        // Vector load cycle; a new exception has to wait
        if_flush_c = 1'b1;
        id_flush_c = 1'b1;
        if (exc_req) begin
          exc_pend_nxt = 1'b1;
        end
        state_nxt = RUN;
      end
      default: begin
        state_nxt     = RUN;
        stall_cnt_nxt = 3'd0;
      end
    endcase
    if (trap_irq || trap_exc) begin
      state_nxt = TRAP;
    end
  end

  // Controller state and registered trap strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      stall_cnt  <= 3'd0;
      exc_pend   <= 1'b0;
      intruption <= 1'b0;
      exception  <= 1'b0;
      irq_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      stall_cnt  <= stall_cnt_nxt;
      exc_pend   <= exc_pend_nxt;
      intruption <= trap_irq;
      exception  <= trap_exc;
      irq_ack    <= trap_irq;
    end
  end

  // Combinational controls are forced low for as long as reset is held
  assign PCSrc    = reset ? SEL_PC4 : pcsrc_c;
  assign IF_Flush = reset ? 1'b0 : if_flush_c;
  assign IF_Pause = reset ? 1'b0 : if_pause_c;
  assign ID_Flush = reset ? 1'b0 : id_flush_c;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl (STALL_CYCLES=3, IRQ_SYNC=2).
// Directed scenarios followed by a randomized run against a behavioural model.
module tb_fetch_ctrl;
  localparam int SC = 3;
  localparam int IS = 2;

  logic clk = 1'b0;
  logic reset, branch_taken, jump, jr, load_use, exc_req, irq_req, kernel_mode;
`ifdef FETCH_CTRL_IRQ_MASK_EN
  logic eret;
`endif
  logic [2:0] PCSrc;
  logic IF_Flush, IF_Pause, ID_Flush, intruption, exception, irq_ack;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_ctrl #(.STALL_CYCLES(SC), .IRQ_SYNC(IS)) dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .load_use(load_use), .exc_req(exc_req), .irq_req(irq_req), .kernel_mode(kernel_mode),
`ifdef FETCH_CTRL_IRQ_MASK_EN
    .eret(eret),
`endif
    .PCSrc(PCSrc), .IF_Flush(IF_Flush), .IF_Pause(IF_Pause), .ID_Flush(ID_Flush),
    .intruption(intruption), .exception(exception), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // {PCSrc, IF_Flush, IF_Pause, ID_Flush, intruption, exception, irq_ack}
  function automatic logic [8:0] outs();
    return {PCSrc, IF_Flush, IF_Pause, ID_Flush, intruption, exception, irq_ack};
  endfunction

  task automatic idle();
    branch_taken = 0; jump = 0; jr = 0; load_use = 0; exc_req = 0;
`ifdef FETCH_CTRL_IRQ_MASK_EN
    eret = 0;
`endif
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    reset = 1; irq_req = 0; kernel_mode = 0; idle();
    branch_taken = 1; jr = 1; load_use = 1;
    @(negedge clk); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL reset_outs got %b want %b", outs(), 9'b0); else n_pass++;
    @(negedge clk);
    reset = 0; idle(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL reset_release got %b want %b", outs(), 9'b0); else n_pass++;
  endtask

  task automatic test_load_use();
    step(); load_use = 1; #1;
    n_checks++;
    if (outs() !== 9'b000_011_000) $display("FAIL lu_first got %b want %b", outs(), 9'b000_011_000); else n_pass++;
    for (int i = 1; i < SC; i++) begin
      step(); #1;
      n_checks++;
      if (outs() !== 9'b000_011_000) $display("FAIL lu_stall%0d got %b want %b", i, outs(), 9'b000_011_000); else n_pass++;
    end
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL lu_done got %b want %b", outs(), 9'b0); else n_pass++;
  endtask

  task automatic test_branch_priority();
    step(); branch_taken = 1; jump = 1; load_use = 1; #1;
    n_checks++;
    if (outs() !== 9'b001_101_000) $display("FAIL br_prio got %b want %b", outs(), 9'b001_101_000); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL br_dropped_lu got %b want %b", outs(), 9'b0); else n_pass++;
    step(); jr = 1; jump = 1; #1;
    n_checks++;
    if (outs() !== 9'b100_100_000) $display("FAIL jr_over_j got %b want %b", outs(), 9'b100_100_000); else n_pass++;
    step(); jump = 1; #1;
    n_checks++;
    if (outs() !== 9'b010_100_000) $display("FAIL jump got %b want %b", outs(), 9'b010_100_000); else n_pass++;
  endtask

  task automatic test_irq();
    step(); kernel_mode = 0; irq_req = 1; #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL irq_c0 got %b want %b", outs(), 9'b0); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL irq_c1 got %b want %b", outs(), 9'b0); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b000_101_000) $display("FAIL irq_accept got %b want %b", outs(), 9'b000_101_000); else n_pass++;
    step(); irq_req = 0; kernel_mode = 1; #1;
    n_checks++;
    if (outs() !== 9'b000_101_101) $display("FAIL irq_trap got %b want %b", outs(), 9'b000_101_101); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL irq_after got %b want %b", outs(), 9'b0); else n_pass++;
    step(); step(); step(); kernel_mode = 0;
  endtask

`ifdef FETCH_CTRL_IRQ_MASK_EN
  task automatic test_irq_mask();
    step(); irq_req = 1; kernel_mode = 0;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      n_checks++;
      if (outs() !== 9'b0) $display("FAIL mask_block%0d got %b want %b", i, outs(), 9'b0); else n_pass++;
    end
    step(); eret = 1; #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL mask_eret got %b want %b", outs(), 9'b0); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b000_101_000) $display("FAIL mask_accept got %b want %b", outs(), 9'b000_101_000); else n_pass++;
    step(); irq_req = 0; kernel_mode = 1; #1;
    n_checks++;
    if (outs() !== 9'b000_101_101) $display("FAIL mask_trap got %b want %b", outs(), 9'b000_101_101); else n_pass++;
    step(); step(); step(); kernel_mode = 0;
  endtask
`endif

  task automatic test_exc_pend();
    step(); kernel_mode = 1; exc_req = 1; #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL pend_latch got %b want %b", outs(), 9'b0); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL pend_wait got %b want %b", outs(), 9'b0); else n_pass++;
    step(); kernel_mode = 0; #1;
    n_checks++;
    if (outs() !== 9'b000_101_000) $display("FAIL pend_accept got %b want %b", outs(), 9'b000_101_000); else n_pass++;
    step(); kernel_mode = 1; #1;
    n_checks++;
    if (outs() !== 9'b000_101_010) $display("FAIL pend_trap got %b want %b", outs(), 9'b000_101_010); else n_pass++;
    step(); #1;
    step(); kernel_mode = 0; #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL pend_cleared got %b want %b", outs(), 9'b0); else n_pass++;
  endtask

  task automatic test_stall_exc();
    step(); kernel_mode = 0; load_use = 1; #1;
    n_checks++;
    if (outs() !== 9'b000_011_000) $display("FAIL se_lu got %b want %b", outs(), 9'b000_011_000); else n_pass++;
    step(); exc_req = 1; #1;
    n_checks++;
    if (ID_Flush !== 1'b1) $display("FAIL se_abort_idflush got %b want 1", ID_Flush); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b000_101_010) $display("FAIL se_trap got %b want %b", outs(), 9'b000_101_010); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL se_run got %b want %b", outs(), 9'b0); else n_pass++;
  endtask

  task automatic test_stall_branch();
    step(); load_use = 1;
    step(); branch_taken = 1; #1;
    n_checks++;
    if (outs() !== 9'b001_101_000) $display("FAIL sb_branch got %b want %b", outs(), 9'b001_101_000); else n_pass++;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL sb_aborted got %b want %b", outs(), 9'b0); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    step(); load_use = 1;
    step(); #1;
    n_checks++;
    if (outs() !== 9'b000_011_000) $display("FAIL rs_stall got %b want %b", outs(), 9'b000_011_000); else n_pass++;
    reset = 1; #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL rs_immediate got %b want %b", outs(), 9'b0); else n_pass++;
    @(negedge clk); reset = 0; #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL rs_no_spurious got %b want %b", outs(), 9'b0); else n_pass++;
    for (int i = 0; i < SC; i++) begin
      step(); load_use = (i == 0); #1;
      n_checks++;
      if (outs() !== 9'b000_011_000) $display("FAIL rs_fresh_stall%0d got %b want %b", i, outs(), 9'b000_011_000); else n_pass++;
    end
    step(); #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL rs_fresh_done got %b want %b", outs(), 9'b0); else n_pass++;
  endtask

  task automatic test_random();
    int  stall_left, trap_cause, nxt_stall, nxt_trap;
    bit  pend, nxt_pend, men, irq_seen;
    bit  hist[$];
    logic [2:0] e_pc;
    logic e_fl, e_pa, e_idf;
    logic [8:0] exp_v;
    @(negedge clk); reset = 1; idle(); irq_req = 0; kernel_mode = 0;
    @(negedge clk); reset = 0;
    stall_left = 0; trap_cause = 0; pend = 0; men = 1;
    hist = {};
    for (int i = 0; i < IS; i++) hist.push_back(1'b0);
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      branch_taken = ($urandom_range(0, 7) == 0);
      jr           = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      load_use     = ($urandom_range(0, 4) == 0);
      exc_req      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) kernel_mode = ~kernel_mode;
      if ($urandom_range(0, 11) == 0) irq_req = ~irq_req;
`ifdef FETCH_CTRL_IRQ_MASK_EN
      eret = ($urandom_range(0, 19) == 0);
`endif
      #1;
      irq_seen = hist[IS-1];
      e_pc = 3'b000; e_fl = 0; e_pa = 0; e_idf = 0;
      nxt_stall = stall_left; nxt_trap = 0; nxt_pend = pend;
      if (trap_cause != 0) begin
        e_fl = 1; e_idf = 1;
        if (exc_req) nxt_pend = 1;
      end else if (stall_left > 0) begin
        if (exc_req && !kernel_mode) begin
          e_fl = 1; e_idf = 1; nxt_trap = 2; nxt_pend = 0; nxt_stall = 0;
        end else begin
          if (exc_req) nxt_pend = 1;
          if (branch_taken) begin
            e_pc = 3'b001; e_fl = 1; e_idf = 1; nxt_stall = 0;
          end else begin
            e_pa = 1; e_idf = 1; nxt_stall = stall_left - 1;
          end
        end
      end else begin
        if ((pend || exc_req) && !kernel_mode) begin
          e_fl = 1; e_idf = 1; nxt_trap = 2; nxt_pend = 0;
        end else begin
          if (exc_req) nxt_pend = 1;
          if (branch_taken) begin e_pc = 3'b001; e_fl = 1; e_idf = 1; end
          else if (jr)      begin e_pc = 3'b100; e_fl = 1; end
          else if (jump)    begin e_pc = 3'b010; e_fl = 1; end
          else if (irq_seen && men && !kernel_mode) begin e_fl = 1; e_idf = 1; nxt_trap = 1; end
          else if (load_use) begin e_pa = 1; e_idf = 1; nxt_stall = SC - 1; end
        end
      end
      exp_v = {e_pc, e_fl, e_pa, e_idf, trap_cause == 1, trap_cause == 2, trap_cause == 1};
      n_checks++;
      if (outs() !== exp_v) $display("FAIL rand_cycle%0d got %b want %b", n, outs(), exp_v); else n_pass++;
      n_checks++;
      if (!$onehot0(PCSrc) || (IF_Pause && IF_Flush))
        $display("FAIL rand_invariant%0d got PCSrc=%b pause=%b flush=%b want onehot0 and not both", n, PCSrc, IF_Pause, IF_Flush);
      else n_pass++;
      @(posedge clk);
      hist.push_front(irq_req);
      void'(hist.pop_back());
`ifdef FETCH_CTRL_IRQ_MASK_EN
      if (nxt_trap != 0) men = 0;
      else if (eret) men = 1;
`endif
      stall_left = nxt_stall; trap_cause = nxt_trap; pend = nxt_pend;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_irq();
`ifdef FETCH_CTRL_IRQ_MASK_EN
    test_irq_mask();
`endif
    test_exc_pend();
    test_stall_exc();
    test_stall_branch();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
